// File: rtl/pyc_sync_mem_mp.sv
// pyc_sync_mem_mp: multi-port synchronous memory with NR registered read ports,
// NW byte-masked write ports, 1- or 2-cycle read latency, selectable
// read-during-write policy and a clear sequencer that zeroes the array.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   ren        per-port read enable (NR)
//   raddr      read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   rvalid     one-cycle pulse per completed read (NR)
//   wvalid     per-port write enable (NW)
//   waddr      write addresses
//   wdata      write data
//   wstrb      byte enables, port w at [w*(DATA_WIDTH/8) +: DATA_WIDTH/8]
//   clr        start a clear sweep
//   busy       clear sweep in progress
module pyc_sync_mem_mp #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned NR         = 2,
  parameter int unsigned NW         = 1,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NR-1:0]                   ren,
  input  logic [NR*ADDR_WIDTH-1:0]        raddr,
  output logic [NR*DATA_WIDTH-1:0]        rdata,
  output logic [NR-1:0]                   rvalid,
  input  logic [NW-1:0]                   wvalid,
  input  logic [NW*ADDR_WIDTH-1:0]        waddr,
  input  logic [NW*DATA_WIDTH-1:0]        wdata,
  input  logic [NW*(DATA_WIDTH/8)-1:0]    wstrb,
  input  logic                            clr,
  output logic                            busy
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Elaboration-time parameter legality checks
  if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_dw
    $fatal(1, "pyc_sync_mem_mp: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH == 0) begin : g_bad_depth
    $fatal(1, "pyc_sync_mem_mp: DEPTH must be > 0");
  end
  if ((NR < 1) || (NR > 8)) begin : g_bad_nr
    $fatal(1, "pyc_sync_mem_mp: NR must be in 1..8");
  end
  if ((NW < 1) || (NW > 4)) begin : g_bad_nw
    $fatal(1, "pyc_sync_mem_mp: NW must be in 1..4");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_lat
    $fatal(1, "pyc_sync_mem_mp: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE > 1) begin : g_bad_rdw
    $fatal(1, "pyc_sync_mem_mp: RDW_MODE must be 0 or 1");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  // Only the low 32 address bits are decoded; narrower addresses zero-extend.
  function automatic logic [31:0] dec_addr(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return dec_addr(a) < 32'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(dec_addr(a));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  clr_we;

  logic [NW-1:0]         w_act;
  logic [IDX_W-1:0]      w_idx [NW];
  logic [NR-1:0]         r_ok;
  logic [IDX_W-1:0]      r_idx [NR];
  logic [NR*DATA_WIDTH-1:0] rd_word;

  logic [NR*DATA_WIDTH-1:0] s1_data_q;
  logic [NR-1:0]            s1_vld_q;

  // Clear sequencer: next state, counter and busy
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // clr is ignored while sweeping
        if (cnt_q == LAST_IDX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  // A reset landing mid-sweep must leave unswept entries untouched
  assign clr_we = (state_q == S_CLEAR) && !rst;

  // Write-port decode; user writes are suppressed during a sweep
  always_comb begin
    w_act = '0;
    for (int w = 0; w < int'(NW); w++) begin
      w_idx[w] = to_idx(waddr[w*ADDR_WIDTH +: ADDR_WIDTH]);
      w_act[w] = wvalid[w] && in_range(waddr[w*ADDR_WIDTH +: ADDR_WIDTH])
                 && (state_q == S_IDLE);
    end
  end

  // Array update; later ports overwrite earlier ones on shared bytes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end
    for (int w = 0; w < int'(NW); w++) begin
      if (w_act[w]) begin
        for (int b = 0; b < int'(NB); b++) begin
          if (wstrb[w*NB + b]) begin
            mem[w_idx[w]][b*8 +: 8] <= wdata[w*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  // Read word per port; write-first mode merges same-cycle writes in port order
  always_comb begin
    rd_word = '0;
    r_ok    = '0;
    for (int p = 0; p < int'(NR); p++) begin
      r_idx[p] = to_idx(raddr[p*ADDR_WIDTH +: ADDR_WIDTH]);
      r_ok[p]  = in_range(raddr[p*ADDR_WIDTH +: ADDR_WIDTH]);
      if (r_ok[p] && (state_q == S_IDLE)) begin
        rd_word[p*DATA_WIDTH +: DATA_WIDTH] = mem[r_idx[p]];
        if (RDW_MODE == 0) begin
          for (int w = 0; w < int'(NW); w++) begin
            if (w_act[w] && (w_idx[w] == r_idx[p])) begin
              for (int b = 0; b < int'(NB); b++) begin
                if (wstrb[w*NB + b]) begin
                  rd_word[p*DATA_WIDTH + b*8 +: 8] = wdata[w*DATA_WIDTH + b*8 +: 8];
                end
              end
            end
          end
        end
      end
    end
  end

  // First read stage: data only moves on an accepted read, so it holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q <= '0;
      s1_vld_q  <= '0;
    end else begin
      s1_vld_q <= ren;
      for (int p = 0; p < int'(NR); p++) begin
        if (ren[p]) begin
          s1_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [NR*DATA_WIDTH-1:0] s2_data_q;
    logic [NR-1:0]            s2_vld_q;

    // Extra output stage; valid travels alongside the data
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_q <= '0;
        s2_vld_q  <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        for (int p = 0; p < int'(NR); p++) begin
          if (s1_vld_q[p]) begin
            s2_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= s1_data_q[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end

    assign rdata  = s2_data_q;
    assign rvalid = s2_vld_q;
  end else begin : g_lat1
    assign rdata  = s1_data_q;
    assign rvalid = s1_vld_q;
  end

endmodule
